// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester family: state encoding,
// default bus widths and compile-time width helpers.
package apb_pkg;

    localparam int DEF_ADDRESS = 8;
    localparam int DEF_DATA    = 8;
    localparam int DEF_NSLAVES = 2;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11,
        ERR    = 2'b10
    } apb_state_t;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Select field width: never narrower than one bit, even for a single responder.
    function automatic int sel_width(input int nslaves);
        return (clog2(nslaves) > 1) ? clog2(nslaves) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational responder decoder: the top SEL_W address bits pick the
// responder; indices beyond NSLAVES raise a decode error with no select.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDRESS = DEF_ADDRESS,
    parameter int NSLAVES = DEF_NSLAVES
) (
    input  logic [ADDRESS-1:0] addr,
    output logic [NSLAVES-1:0] sel,
    output logic               err
);

    localparam int SEL_W = sel_width(NSLAVES);

    logic [SEL_W-1:0] idx;
    logic             unused_low_bits;

    assign idx             = addr[ADDRESS-1 -: SEL_W];
    assign unused_low_bits = ^addr[ADDRESS-SEL_W-1:0];

    // One-hot select for an in-range index, error flag otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        sel = '0;
        err = 1'b1;
        for (int k = 0; k < NSLAVES; k++) begin
            if (idx == SEL_W'(k)) begin
                sel[k] = 1'b1;
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: takes one command at a time on a valid/ready port, runs
// SETUP -> ACCESS on the selected responder and returns a one-cycle response.
// Optional macro APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT
// cycles without PREADY; without it ACCESS waits indefinitely.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDRESS = DEF_ADDRESS,
    parameter int DATA    = DEF_DATA,
    parameter int NSLAVES = DEF_NSLAVES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS-1:0]      cmd_addr,
    input  logic [DATA-1:0]         cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATA-1:0]         rsp_rdata,
    output logic                    rsp_err,
    output logic [NSLAVES-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDRESS-1:0]      PADDR,
    output logic [DATA-1:0]         PWDATA,
    input  logic [NSLAVES*DATA-1:0] PRDATA,
    input  logic [NSLAVES-1:0]      PREADY
);

    apb_state_t         state;
    apb_state_t         next_state;
    logic [NSLAVES-1:0] dec_sel;
    logic               dec_err;
    logic               accept;
    logic               ready_hit;
    logic               complete;
    logic               fail;
    logic               timeout_hit;
    logic [DATA-1:0]    slave_rdata;

    apb_addr_decoder #(
        .ADDRESS (ADDRESS),
        .NSLAVES (NSLAVES)
    ) u_decoder (
        .addr (cmd_addr),
        .sel  (dec_sel),
        .err  (dec_err)
    );

    // Only the registered select qualifies PREADY, so other responders are ignored.
    assign ready_hit = |(PSEL & PREADY);

    // Pick the selected responder's read slice with the one-hot select.
    always_comb begin
        slave_rdata = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (PSEL[k]) begin
                slave_rdata = PRDATA[k*DATA +: DATA];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count unanswered ACCESS cycles; cleared in SETUP so every transfer starts at zero.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !ready_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A late PREADY on the abort edge still completes normally.
    assign timeout_hit = (state == ACCESS) && !ready_hit && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = dec_err ? ERR : SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (complete || timeout_hit) next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state control strobes; cmd_ready is the only unregistered output.
    always_comb begin
        cmd_ready = (state == IDLE);
        accept    = cmd_valid && (state == IDLE);
        complete  = (state == ACCESS) && ready_hit;
        fail      = (state == ERR) || timeout_hit;
    end

    // Registered bus and response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                PWRITE  <= cmd_write;
                PADDR   <= cmd_addr;
                PWDATA  <= cmd_wdata;
                PSEL    <= dec_sel;
                PENABLE <= 1'b0;
            end
            if (state == SETUP) begin
                PENABLE <= 1'b1;
            end
            if (complete) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= PWRITE ? '0 : slave_rdata;
                PSEL      <= '0;
                PENABLE   <= 1'b0;
            end
            if (fail) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
                PSEL      <= '0;
                PENABLE   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with three RAM responders on the bus.
// The driver pushes the expected response from a memory-level reference model;
// an independent monitor pops and compares whenever rsp_valid is seen.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 3;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_ON = 1'b0;
`endif

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [DW-1:0]    cmd_wdata;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [NS-1:0]    PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]    PREADY;

    apb_master_bridge #(
        .ADDRESS (AW),
        .DATA    (DW),
        .NSLAVES (NS),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- responders (environment) ----------------
    logic [DW-1:0] resp_mem [NS][256];
    logic [DW-1:0] ref_mem  [NS][256];
    logic          mem_load;
    int            cur_wait;
    int            acc_cnt = 0;

    always_comb begin
        for (int k = 0; k < NS; k++) PRDATA[k*DW +: DW] = resp_mem[k][PADDR];
    end

    always @(posedge PCLK) begin
        if (mem_load) begin
            for (int k = 0; k < NS; k++)
                for (int a = 0; a < 256; a++) resp_mem[k][a] <= ref_mem[k][a];
        end else begin
            for (int k = 0; k < NS; k++)
                if (PSEL[k] && PENABLE && PREADY[k] && PWRITE) resp_mem[k][PADDR] <= PWDATA;
        end
    end

    // Selected responder answers after cur_wait ACCESS cycles; the rest toggle randomly.
    always @(negedge PCLK) begin : responder_ready
        logic [NS-1:0] r;
        r = NS'($urandom);
        if (PENABLE === 1'b1 && |PSEL) begin
            for (int k = 0; k < NS; k++) if (PSEL[k]) r[k] = (acc_cnt == cur_wait);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
        PREADY = r;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] cur_addr;
    logic          cur_write;
    logic [DW-1:0] cur_wdata;
    logic [NS-1:0] cur_sel;

    always @(negedge PCLK) begin : monitor
        exp_t e;
        if (PRESET === 1'b0) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, want no response (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_cycle", cyc, e.due);
                    check("ready_with_rsp", cmd_ready, 1);
                end
            end
            if (|PSEL) begin
                check("bus_psel", PSEL, cur_sel);
                check("bus_paddr", PADDR, cur_addr);
                check("bus_pwrite", PWRITE, cur_write);
                check("bus_pwdata", PWDATA, cur_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int wt, input int gap, input bit track);
        int   idx;
        int   budget;
        int   acc;
        exp_t e;
        repeat (gap) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
        end
        budget = 0;
        @(negedge PCLK);
        while (!cmd_ready && budget < 200) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            budget++;
            @(negedge PCLK);
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: got cmd_ready=0 for 200 cycles, want 1");
            cmd_valid = 1'b0;
            return;
        end
        idx       = int'(addr[AW-1 -: 2]);
        cur_addr  = addr;
        cur_write = wr;
        cur_wdata = wd;
        cur_sel   = (idx < NS) ? NS'(1 << idx) : '0;
        cur_wait  = wt;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        // Reference model: responders are plain RAMs, decode errors and timeouts leave them alone.
        if (idx >= NS) begin
            e.err = 1'b1; e.rdata = '0; e.due = 1;
        end else if (TO_ON && wt >= TO) begin
            e.err = 1'b1; e.rdata = '0; e.due = 1 + TO;
        end else begin
            e.err = 1'b0; e.due = 2 + wt;
            if (wr) begin
                ref_mem[idx][addr] = wd;
                e.rdata = '0;
            end else begin
                e.rdata = ref_mem[idx][addr];
            end
        end
        @(posedge PCLK);
        #1;
        acc = cyc;
        if (track) begin
            e.due = e.due + acc;
            exp_q.push_back(e);
        end
        @(negedge PCLK);
        check("first_psel", PSEL, cur_sel);
        check("first_penable", PENABLE, 0);
        check("busy_not_ready", cmd_ready, 0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            budget++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 256; a++) ref_mem[k][a] = DW'($urandom);
        ref_mem[0][8'h85] = 8'hC3;
        ref_mem[2][8'h85] = 8'h3C;
        mem_load  = 1'b1;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cur_wait  = 0;
        cur_sel   = '0;
        cur_addr  = '0;
        cur_write = 1'b0;
        cur_wdata = '0;
        repeat (3) @(negedge PCLK);
        mem_load = 1'b0;

        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        PRESET = 1'b0;

        // Directed: write/read back, responder select, wait states, decode errors.
        issue(1'b1, 8'h05, 8'hA5, 0, 0, 1'b1);
        issue(1'b0, 8'h05, 8'h00, 0, 0, 1'b1);
        issue(1'b0, 8'h85, 8'h00, 0, 0, 1'b1);
        issue(1'b0, 8'h45, 8'h00, 1, 0, 1'b1);
        issue(1'b1, 8'h4A, 8'h5E, 3, 1, 1'b1);
        issue(1'b0, 8'h4A, 8'h00, 3, 0, 1'b1);
        issue(1'b0, 8'hC0, 8'h00, 0, 0, 1'b1);
        issue(1'b1, 8'hFF, 8'h11, 0, 0, 1'b1);
        issue(1'b0, 8'h05, 8'h00, 2, 0, 1'b1);
        drain();

        // Reset while ACCESS waits on PREADY: the command is dropped silently.
        issue(1'b0, 8'h47, 8'h00, 1000, 0, 1'b0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("access_before_reset", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("rst_mid_psel", PSEL, 0);
        check("rst_mid_penable", PENABLE, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_no_rsp", rsp_valid, 0);
        cmd_valid = 1'b0;
        PRESET    = 1'b0;
        drain();

`ifdef APB_MASTER_TIMEOUT_EN
        // Abort leaves the RAM unwritten; PREADY on the abort edge still completes.
        issue(1'b1, 8'h10, 8'h77, TO, 0, 1'b1);
        issue(1'b0, 8'h10, 8'h00, TO - 1, 0, 1'b1);
        issue(1'b0, 8'h50, 8'h00, TO + 2, 0, 1'b1);
        issue(1'b0, 8'h10, 8'h00, 0, 0, 1'b1);
        drain();
`endif

        // Randomized traffic.
        repeat (120) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                  $urandom_range(0, TO_ON ? TO + 1 : 5), $urandom_range(0, 2), 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
